// File: rtl/fir_pkg.sv
// fir_pkg -- shared definitions for the FIR input stage.
//   DATA_W / COEF_W : sample and coefficient widths
//   NTAPS           : number of active coefficients (B0..B6)
//   FLUSH_LEN       : zero-sample cycles emitted after streaming stops
//   fir_state_t     : controller state type and its encodings
//   sat_inc8        : saturating 8-bit increment helper
package fir_pkg;

  localparam int DATA_W    = 8;
  localparam int COEF_W    = 8;
  localparam int NTAPS     = 7;
  localparam int FLUSH_LEN = NTAPS;

  typedef logic [1:0] fir_state_t;

  localparam fir_state_t ST_IDLE  = 2'd0;
  localparam fir_state_t ST_PRIME = 2'd1;
  localparam fir_state_t ST_RUN   = 2'd2;
  localparam fir_state_t ST_FLUSH = 2'd3;

  // Increment that sticks at 8'hFF instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo -- circular sample buffer, DEPTH entries (power of two).
//   push/push_data : write request; honoured when not full, or when a pop
//                    happens in the same cycle (occupancy then unchanged)
//   pop/pop_data   : read request; pop_data is the current head (show-ahead);
//                    a pop on an empty buffer is ignored
//   full/empty     : occupancy flags
//   level          : current occupancy, 0..DEPTH
module fir_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic          full_s, empty_s;
  logic          push_ok_s, pop_ok_s;

  assign full_s   = (level_q == LW'(DEPTH));
  assign empty_s  = (level_q == {LW{1'b0}});
  assign full     = full_s;
  assign empty    = empty_s;
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointers / occupancy.
  always_comb begin
    pop_ok_s  = pop && !empty_s;
    // A push into a full buffer is legal only when the head leaves this cycle.
    push_ok_s = push && (!full_s || pop_ok_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    level_d = level_q + LW'(push_ok_s) - LW'(pop_ok_s);
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

endmodule

// File: rtl/fir_input_stage.sv
// fir_input_stage -- buffers upstream samples and streams them to a 7-tap FIR,
// and manages a double-buffered coefficient bank.
//   in_valid/in_data/in_ready : upstream sample handshake (in_ready registered)
//   run                       : level request to stream samples
//   coef_we/addr/data         : shadow coefficient write (addr 7 ignored)
//   coef_commit/coef_pending  : shadow->active copy request / copy outstanding
//   xin/xin_valid             : registered sample to the filter
//   b0..b6                    : registered active coefficients
//   underrun_cnt              : saturating count of RUN cycles with no sample
//   frame_done                : one-cycle pulse at the end of the flush
module fir_input_stage
  import fir_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int PRIME_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              run,
  input  logic              coef_we,
  input  logic [2:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              coef_commit,
  output logic              coef_pending,
  output logic [DATA_W-1:0] xin,
  output logic              xin_valid,
  output logic [COEF_W-1:0] b0,
  output logic [COEF_W-1:0] b1,
  output logic [COEF_W-1:0] b2,
  output logic [COEF_W-1:0] b3,
  output logic [COEF_W-1:0] b4,
  output logic [COEF_W-1:0] b5,
  output logic [COEF_W-1:0] b6,
  output logic [7:0]        underrun_cnt,
  output logic              frame_done
);

  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int FCW = $clog2(FLUSH_LEN);

  fir_state_t        state_q, state_d;
  logic [FCW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [DATA_W-1:0] xin_q, xin_d;
  logic              xin_valid_q, xin_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        underrun_q, underrun_d;
  logic              in_ready_q, in_ready_d;
  logic [COEF_W-1:0] shadow_q [NTAPS];
  logic [COEF_W-1:0] shadow_d [NTAPS];
  logic [COEF_W-1:0] coef_q   [NTAPS];
  logic [COEF_W-1:0] coef_d   [NTAPS];
  logic              pending_q, pending_d;

  logic              push_s, pop_s;
  logic [DATA_W-1:0] head_s;
  logic              full_s, empty_s;
  logic [LW-1:0]     level_s, level_next_s;

  fir_sample_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (in_data),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (level_s)
  );

  // in_ready_q already implies not-full; the full term keeps the FIFO safe
  // should the two ever disagree.
  assign push_s = in_valid && in_ready_q && !full_s;

  // Stream controller: next state, pop decision and next filter outputs.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    xin_d        = {DATA_W{1'b0}};
    xin_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    underrun_d   = underrun_q;
    pop_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_PRIME;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (level_s >= LW'(PRIME_LEVEL)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PRIME;
        end
      end
      ST_RUN: begin
        xin_valid_d = 1'b1;
        if (!run) begin
          // The stop cycle itself is the first of the FLUSH_LEN zero samples.
          state_d     = ST_FLUSH;
          flush_cnt_d = {FCW{1'b0}};
        end else if (!empty_s) begin
          pop_s = 1'b1;
          xin_d = head_s;
        end else begin
          underrun_d = sat_inc8(underrun_q);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FCW'(FLUSH_LEN - 1)) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + FCW'(1);
          xin_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Occupancy after this edge decides whether upstream may push next cycle.
  always_comb begin
    level_next_s = level_s + LW'(push_s) - LW'(pop_s);
    in_ready_d   = (level_next_s != LW'(DEPTH));
  end

  // Shadow writes and shadow->active copy; copies happen only from IDLE so the
  // active bank is frozen while streaming.
  always_comb begin
    shadow_d  = shadow_q;
    coef_d    = coef_q;
    pending_d = pending_q;
    for (int i = 0; i < NTAPS; i++) begin
      if (coef_we && (coef_addr == 3'(i))) begin
        shadow_d[i] = coef_data;
      end else begin
        shadow_d[i] = shadow_q[i];
      end
    end
    // Copy from shadow_d so a write in the commit cycle is included.
    if ((state_q == ST_IDLE) && (coef_commit || pending_q)) begin
      coef_d    = shadow_d;
      pending_d = 1'b0;
    end else if (coef_commit) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  // Controller, output and coefficient registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= {FCW{1'b0}};
      xin_q        <= {DATA_W{1'b0}};
      xin_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 8'd0;
      in_ready_q   <= 1'b0;
      pending_q    <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        shadow_q[i] <= {COEF_W{1'b0}};
        coef_q[i]   <= {COEF_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      xin_q        <= xin_d;
      xin_valid_q  <= xin_valid_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      in_ready_q   <= in_ready_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      coef_q       <= coef_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign xin          = xin_q;
  assign xin_valid    = xin_valid_q;
  assign frame_done   = frame_done_q;
  assign underrun_cnt = underrun_q;
  assign coef_pending = pending_q;
  assign b0 = coef_q[0];
  assign b1 = coef_q[1];
  assign b2 = coef_q[2];
  assign b3 = coef_q[3];
  assign b4 = coef_q[4];
  assign b5 = coef_q[5];
  assign b6 = coef_q[6];

endmodule

// File: tb/tb_fir_input_stage.sv
// tb_fir_input_stage -- directed and randomized stimulus for fir_input_stage,
// every cycle compared against a queue-based reference model.
module tb_fir_input_stage;

  localparam int DEPTH = 8;
  localparam int PRIME = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready;
  logic       run = 1'b0;
  logic       coef_we = 1'b0;
  logic [2:0] coef_addr = 3'd0;
  logic [7:0] coef_data = 8'd0;
  logic       coef_commit = 1'b0;
  logic       coef_pending;
  logic [7:0] xin;
  logic       xin_valid;
  logic [7:0] b0, b1, b2, b3, b4, b5, b6;
  logic [7:0] underrun_cnt;
  logic       frame_done;
  logic [7:0] b_arr [7];

  assign b_arr[0] = b0;
  assign b_arr[1] = b1;
  assign b_arr[2] = b2;
  assign b_arr[3] = b3;
  assign b_arr[4] = b4;
  assign b_arr[5] = b5;
  assign b_arr[6] = b6;

  fir_input_stage #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .run(run), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_commit(coef_commit), .coef_pending(coef_pending),
    .xin(xin), .xin_valid(xin_valid), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .b4(b4), .b5(b5), .b6(b6), .underrun_cnt(underrun_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 prime, 2 streaming, 3 flushing.
  int q[$];
  int m_mode, m_flush_left, m_und;
  int m_sh [7];
  int m_act [7];
  bit m_pend, m_ready;
  int e_x, e_v, e_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = 0; m_flush_left = 0; m_und = 0;
    m_pend = 1'b0; m_ready = 1'b0;
    e_x = 0; e_v = 0; e_done = 0;
    for (int i = 0; i < 7; i++) begin
      m_sh[i] = 0;
      m_act[i] = 0;
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ":xin"}, 32'(xin), 32'(e_x));
    check({ph, ":xin_valid"}, 32'(xin_valid), 32'(e_v));
    check({ph, ":frame_done"}, 32'(frame_done), 32'(e_done));
    check({ph, ":in_ready"}, 32'(in_ready), 32'(m_ready));
    check({ph, ":coef_pending"}, 32'(coef_pending), 32'(m_pend));
    check({ph, ":underrun_cnt"}, 32'(underrun_cnt), 32'(m_und));
    for (int i = 0; i < 7; i++) begin
      check($sformatf("%s:b%0d", ph, i), 32'(b_arr[i]), 32'(m_act[i]));
    end
  endtask

  // One clock cycle: drive inputs, predict the edge, then compare.
  task automatic step(input string ph, input bit v, input int d, input bit r,
                      input bit we, input int a, input int cd, input bit cm);
    int  old_mode;
    bit  accept;
    in_valid = v; in_data = 8'(d); run = r;
    coef_we = we; coef_addr = 3'(a); coef_data = 8'(cd); coef_commit = cm;
    accept = v && m_ready;
    old_mode = m_mode;
    e_x = 0; e_v = 0; e_done = 0;
    case (m_mode)
      0: if (r) m_mode = 1;
      1: begin
        if (!r) m_mode = 0;
        else if (q.size() >= PRIME) m_mode = 2;
      end
      2: begin
        e_v = 1;
        if (!r) begin
          m_mode = 3;
          m_flush_left = 6;
        end else if (q.size() > 0) begin
          e_x = q.pop_front();
        end else begin
          m_und = (m_und < 255) ? m_und + 1 : 255;
        end
      end
      default: begin
        if (m_flush_left > 0) begin
          m_flush_left--;
          e_v = 1;
        end else begin
          m_mode = 0;
          e_done = 1;
        end
      end
    endcase
    if (accept) q.push_back(d & 255);
    if (we && a < 7) m_sh[a] = cd & 255;
    if (old_mode == 0 && (cm || m_pend)) begin
      m_act = m_sh;
      m_pend = 1'b0;
    end else if (cm) begin
      m_pend = 1'b1;
    end
    m_ready = (q.size() < DEPTH);
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic idle_step(input string ph, input bit r);
    step(ph, 1'b0, 0, r, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    bit rr;
    model_reset();
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    idle_step("release", 1'b0);
    check("in_ready_rise", 32'(in_ready), 32'd1);

    // Push 1..4 then start streaming: 1,2,3,4 back to back.
    for (int i = 1; i <= 4; i++) step("push4", 1'b1, i, 1'b0, 1'b0, 0, 0, 1'b0);
    repeat (3) idle_step("start", 1'b1);
    check("first_sample", 32'(xin), 32'd1);
    repeat (3) idle_step("stream4", 1'b1);
    check("fourth_sample", 32'(xin), 32'd4);

    // Drained FIFO: underrun count saturates.
    repeat (300) idle_step("drain", 1'b1);
    check("underrun_sat", 32'(underrun_cnt), 32'd255);

    // Shadow write and commit while streaming; bank frozen until IDLE.
    step("wr_sh3", 1'b1, 8'h11, 1'b1, 1'b1, 3, 8'h40, 1'b0);
    step("commit_run", 1'b1, 8'h22, 1'b1, 1'b0, 0, 0, 1'b1);
    check("pending_set", 32'(coef_pending), 32'd1);
    check("b3_frozen", 32'(b3), 32'd0);
    for (int i = 0; i < 4; i++) step("run_push", 1'b1, $urandom_range(0, 255), 1'b1, 1'b0, 0, 0, 1'b0);

    // Stop: 7 zero cycles while pushes accumulate, then Frame_Done and IDLE.
    for (int i = 0; i < 8; i++) step("flush", 1'b1, 100 + i, 1'b0, 1'b0, 0, 0, 1'b0);
    check("frame_done_pulse", 32'(frame_done), 32'd1);
    idle_step("idle_copy", 1'b0);
    check("b3_committed", 32'(b3), 32'h40);
    check("pending_clear", 32'(coef_pending), 32'd0);

    // Fill to full with no pops; further pushes are ignored.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 200 + i, 1'b0, 1'b0, 0, 0, 1'b0);
    check("in_ready_full", 32'(in_ready), 32'd0);

    // Stream leftovers with upstream pushing continuously.
    for (int i = 0; i < 20; i++) step("leftover", 1'b1, $urandom_range(0, 255), 1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) idle_step("stop2", 1'b0);

    // Same-cycle write and commit in IDLE takes the new value.
    step("wr_commit", 1'b0, 0, 1'b0, 1'b1, 5, 8'h5A, 1'b1);
    check("b5_same_cycle", 32'(b5), 32'h5A);
    step("addr7", 1'b0, 0, 1'b0, 1'b1, 7, 8'hFF, 1'b1);

    // Randomized phase.
    rr = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 4) rr = ~rr;
      step("rand", ($urandom_range(0, 99) < 55), $urandom_range(0, 255), rr,
           ($urandom_range(0, 99) < 20), $urandom_range(0, 7),
           $urandom_range(0, 255), ($urandom_range(0, 99) < 5));
    end

    // Asynchronous reset while streaming discards FIFO and pending commit.
    for (int i = 0; i < 6; i++) step("pre_rst", 1'b1, i + 1, 1'b1, 1'b0, 0, 0, 1'b0);
    step("pre_rst_cm", 1'b1, 7, 1'b1, 1'b1, 1'b1 ? 2 : 0, 8'h33, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("in_rst");
    rst_n = 1'b1;
    idle_step("post_rst", 1'b0);
    for (int i = 0; i < 60; i++) begin
      step("post_rand", ($urandom_range(0, 99) < 50), $urandom_range(0, 255),
           (i > 3 && i < 40), 1'b0, 0, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
